io_ports: RTL and testbench
===========================

# io_ports

Parametrised I/O port block for the single-cycle CPU datapath. It generalises the fixed four-input-mux / four-output-register arrangement to NPORTS ports of WIDTH bits. All output registers are clocked by `clk` with write enables instead of strobe-clocked registers. It adds per-port input synchronisers, change detection, sticky maskable event flags with read-to-clear, and a single interrupt request line. It sits between the datapath (data from the register file / immediate, selects from opcode fields and control unit) and the chip pins.

## Interface
- WIDTH, 8, data width of every port
- NPORTS, 4, number of input ports and number of output ports (1..16)
- SYNC_STAGES, 2, synchroniser flops per input bit (2..4)
- SELW (localparam), max(1, clog2(NPORTS)), select width

Clock and reset: one clock `clk`; `reset` is synchronous, active-high.

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- out_we  in  1  write enable for output register `out_sel`
- out_sel  in  SELW  output port select
- out_data  in  WIDTH  data written to selected output register
- out_ports  out  NPORTS*WIDTH  output registers, port k at bits [k*WIDTH +: WIDTH]
- in_ports  in  NPORTS*WIDTH  asynchronous input pins, same packing
- in_sel  in  SELW  input port select
- in_data  out  WIDTH  synchronised value of port `in_sel` (combinational mux)
- in_rd  in  1  read strobe; clears pending flag of `in_sel`
- ev_en  in  NPORTS  per-port event enable mask
- ev_pending  out  NPORTS  sticky change flags
- irq  out  1  OR of ev_pending

## Operation
- Output registers: on a clock edge with out_we=1 and out_sel<NPORTS, out_ports[out_sel] <= out_data. If out_sel>=NPORTS the write is dropped and no register changes. Other ports hold.
- Synchroniser: each input bit passes through SYNC_STAGES flops. sync[k] is the last stage. in_data = sync[in_sel], or 0 when in_sel>=NPORTS.
- Change detect: register prev[k] <= sync[k] every cycle. chg[k] = (sync[k] != prev[k]) and warm-up done and ev_en[k].
- Pending: ev_pending[k] is set by chg[k] and cleared by in_rd with in_sel==k. If set and clear happen in the same cycle, set wins and the flag stays 1. in_rd with in_sel>=NPORTS has no effect.
- Masking: clearing ev_en[k] blocks new sets. It does not clear an already-pending flag.
- Warm-up: a counter runs from 0 to SYNC_STAGES+1 after reset and saturates there. chg is suppressed while the count is below SYNC_STAGES+1, so pins that are static and non-zero at reset do not raise events.
- irq = |ev_pending, combinational from the flag register.
- Reset values: out_ports=0, sync flops=0, prev=0, ev_pending=0, warm-up counter=0, irq=0. in_data reads 0 until the synchroniser fills.
- Reset asserted mid-operation overrides every concurrent write, set and clear in that cycle.

## Timing
- Output write latency: 1 cycle. out_ports updates at the edge that samples out_we.
- Input latency: a pin change that is stable before edge E appears on in_data after edge E+SYNC_STAGES-1.
- Event latency: ev_pending (and irq) rise one edge after in_data changes, at edge E+SYNC_STAGES.
- Clear latency: the flag drops at the edge sampling in_rd. irq falls in the same cycle if no other flag is pending.
- Pulses narrower than one clock may be missed. This is acceptable.
- A pin toggling every cycle keeps its flag set. Clears are lost while changes continue.
- NPORTS=1: out_sel and in_sel are 1 bit, and select value 1 is out of range.

## Test plan
- Reset with in_ports=0xA5 on all ports (WIDTH=8, NPORTS=4): release reset, wait 10 cycles -> ev_pending=0000, irq=0, in_data=0xA5 from cycle 2 after release, out_ports=0.
- Output write: out_we=1, out_sel=2, out_data=0x3C for 1 cycle -> port2 reads 0x3C on the next cycle, other ports 0. out_sel=5 with NPORTS=4 (SELW=2 wraps) is tested with NPORTS=3 and out_sel=3 -> no change.
- Event and clear: ev_en=1111, port1 goes 0x00 -> 0x01 -> in_data(sel=1)=0x01 after 2 edges, ev_pending=0010 and irq=1 after 3 edges. Then in_rd=1 with in_sel=1 -> ev_pending=0000, irq=0 next cycle.
- Set/clear collision: port0 changes so that chg lands in the same cycle as in_rd with in_sel=0 -> ev_pending[0] remains 1.
- Mask: ev_en=1011, port2 changes -> ev_pending stays 0000. Then set ev_en=1111 with no further change -> still 0000.
- Mid-operation reset: with ev_pending=1111 and out_ports non-zero, assert reset for 1 cycle together with out_we=1 -> all outputs 0. Warm-up restarts, and no events fire for SYNC_STAGES+1 cycles after release.

Source files
------------

// File: rtl/io_ports.sv
// Parametrised I/O port block: write-enabled output registers, synchronised input
// mux, per-port change detection with sticky maskable event flags and one irq line.
module io_ports #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NPORTS      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned SELW       = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    out_we,
  input  logic [SELW-1:0]         out_sel,
  input  logic [WIDTH-1:0]        out_data,
  output logic [NPORTS*WIDTH-1:0] out_ports,
  input  logic [NPORTS*WIDTH-1:0] in_ports,
  input  logic [SELW-1:0]         in_sel,
  output logic [WIDTH-1:0]        in_data,
  input  logic                    in_rd,
  input  logic [NPORTS-1:0]       ev_en,
  output logic [NPORTS-1:0]       ev_pending,
  output logic                    irq
);

  localparam int unsigned WarmMax = SYNC_STAGES + 1;
  localparam int unsigned CntW    = $clog2(WarmMax + 1);

  logic [NPORTS-1:0][WIDTH-1:0]                  out_q, out_d;
  logic [SYNC_STAGES-1:0][NPORTS-1:0][WIDTH-1:0] sync_q;
  logic [NPORTS-1:0][WIDTH-1:0]                  sync, prev_q;
  logic [CntW-1:0]                               warm_q, warm_d;
  logic                                          warm_done;
  logic [NPORTS-1:0]                             chg, pend_q, pend_d;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == CntW'(WarmMax));

  // Out-of-range selects match no port, so such writes, reads and clears vanish.
  always_comb begin
    out_d   = out_q;
    in_data = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (out_we && (out_sel == SELW'(k))) begin
        out_d[k] = out_data;
      end
      if (in_sel == SELW'(k)) begin
        in_data = sync[k];
      end
    end
  end

  // Set has priority over a same-cycle read clear.
  always_comb begin
    chg    = '0;
    pend_d = '0;
    for (int k = 0; k < NPORTS; k++) begin
      chg[k]    = (sync[k] != prev_q[k]) && warm_done && ev_en[k];
      pend_d[k] = chg[k] | (pend_q[k] & ~(in_rd && (in_sel == SELW'(k))));
    end
  end

  always_comb begin
    warm_d = warm_q;
    if (!warm_done) begin
      warm_d = warm_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      sync_q <= '0;
      prev_q <= '0;
      warm_q <= '0;
      pend_q <= '0;
    end else begin
      out_q     <= out_d;
      sync_q[0] <= in_ports;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync;
      warm_q <= warm_d;
      pend_q <= pend_d;
    end
  end

  assign out_ports  = out_q;
  assign ev_pending = pend_q;
  assign irq        = |pend_q;

endmodule

// File: tb/tb_io_ports.sv
// Self-checking bench for io_ports: directed vectors, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_io_ports;

  localparam int unsigned S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        out_we;
  logic [1:0]  out_sel;
  logic [7:0]  out_data;
  logic [31:0] out_ports;
  logic [31:0] in_ports;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic        in_rd;
  logic [3:0]  ev_en;
  logic [3:0]  ev_pending;
  logic        irq;

  // Second instance with NPORTS=3 so that select value 3 is out of range.
  logic        out_we3;
  logic [1:0]  out_sel3;
  logic [7:0]  out_data3;
  logic [23:0] out_ports3;
  logic [23:0] in_ports3;
  logic [1:0]  in_sel3;
  logic [7:0]  in_data3;
  logic        in_rd3;
  logic [2:0]  ev_en3;
  logic [2:0]  ev_pending3;
  logic        irq3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_ports #(.WIDTH(8), .NPORTS(4), .SYNC_STAGES(S)) u_dut (
    .clk(clk), .reset(reset), .out_we(out_we), .out_sel(out_sel), .out_data(out_data),
    .out_ports(out_ports), .in_ports(in_ports), .in_sel(in_sel), .in_data(in_data),
    .in_rd(in_rd), .ev_en(ev_en), .ev_pending(ev_pending), .irq(irq)
  );

  io_ports #(.WIDTH(8), .NPORTS(3), .SYNC_STAGES(S)) u_dut3 (
    .clk(clk), .reset(reset), .out_we(out_we3), .out_sel(out_sel3), .out_data(out_data3),
    .out_ports(out_ports3), .in_ports(in_ports3), .in_sel(in_sel3), .in_data(in_data3),
    .in_rd(in_rd3), .ev_en(ev_en3), .ev_pending(ev_pending3), .irq(irq3)
  );

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [31:0] exp;
  } wr_vec_t;

  wr_vec_t wr_tab[6];

  // Reference model: q holds the pin vectors sampled at recent edges, newest first.
  logic [31:0] m_q[$];
  logic [7:0]  m_out[4];
  logic [3:0]  m_pend;
  int          m_since;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i <= S; i++) m_q.push_back(32'h0);
    for (int k = 0; k < 4; k++) m_out[k] = 8'h0;
    m_pend  = 4'h0;
    m_since = 0;
  endtask

  task automatic model_edge();
    logic [31:0] cur, old;
    cur = m_q[S-1];
    old = m_q[S];
    for (int k = 0; k < 4; k++) begin
      logic c;
      c = (m_since >= S + 1) && ev_en[k] && (cur[k*8 +: 8] != old[k*8 +: 8]);
      if (in_rd && (int'(in_sel) == k)) m_pend[k] = 1'b0;
      if (c) m_pend[k] = 1'b1;
    end
    if (out_we) m_out[out_sel] = out_data;
    m_q.push_front(in_ports);
    void'(m_q.pop_back());
    if (m_since < S + 1) m_since++;
  endtask

  task automatic model_check();
    logic [31:0] syn, exp_out;
    syn     = m_q[S-1];
    exp_out = {m_out[3], m_out[2], m_out[1], m_out[0]};
    chk("rand_out_ports", out_ports, exp_out);
    chk("rand_in_data", {24'h0, in_data}, {24'h0, syn[in_sel*8 +: 8]});
    chk("rand_ev_pending", {28'h0, ev_pending}, {28'h0, m_pend});
    chk("rand_irq", {31'h0, irq}, {31'h0, |m_pend});
  endtask

  initial begin
    wr_tab[0] = '{we: 1'b1, sel: 2'd2, data: 8'h3C, exp: 32'h003C_0000};
    wr_tab[1] = '{we: 1'b0, sel: 2'd1, data: 8'hFF, exp: 32'h003C_0000};
    wr_tab[2] = '{we: 1'b1, sel: 2'd0, data: 8'h11, exp: 32'h003C_0011};
    wr_tab[3] = '{we: 1'b1, sel: 2'd3, data: 8'hAB, exp: 32'hAB3C_0011};
    wr_tab[4] = '{we: 1'b1, sel: 2'd2, data: 8'h00, exp: 32'hAB00_0011};
    wr_tab[5] = '{we: 1'b0, sel: 2'd3, data: 8'h5A, exp: 32'hAB00_0011};

    reset = 1'b1; out_we = 1'b0; out_sel = '0; out_data = '0;
    in_ports = {4{8'hA5}}; in_sel = '0; in_rd = 1'b0; ev_en = 4'hF;
    out_we3 = 1'b0; out_sel3 = '0; out_data3 = '0; in_ports3 = 24'h123456;
    in_sel3 = '0; in_rd3 = 1'b0; ev_en3 = '0;

    // Reset with static non-zero pins
    step(); step();
    chk("reset_out_ports", out_ports, 32'h0);
    chk("reset_pending", {28'h0, ev_pending}, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    chk("reset_in_data", {24'h0, in_data}, 32'h0);
    chk("reset_out_ports3", {8'h0, out_ports3}, 32'h0);
    reset = 1'b0;
    step();
    chk("sync_cycle1", {24'h0, in_data}, 32'h0);
    step();
    chk("sync_cycle2", {24'h0, in_data}, 32'hA5);
    for (int i = 0; i < 8; i++) step();
    chk("static_pins_no_event", {28'h0, ev_pending}, 32'h0);
    chk("static_pins_no_irq", {31'h0, irq}, 32'h0);

    // Output write vectors
    for (int i = 0; i < 6; i++) begin
      out_we = wr_tab[i].we; out_sel = wr_tab[i].sel; out_data = wr_tab[i].data;
      step();
      chk($sformatf("out_write_%0d", i), out_ports, wr_tab[i].exp);
    end
    out_we = 1'b0;

    // Drop all pins to zero and drain the resulting flags
    in_ports = 32'h0;
    for (int i = 0; i < 4; i++) step();
    chk("all_change_pending", {28'h0, ev_pending}, 32'hF);
    in_rd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_sel = 2'(k);
      step();
    end
    in_rd = 1'b0;
    chk("drain_pending", {28'h0, ev_pending}, 32'h0);

    // Port1 event and read clear
    in_ports = 32'h0000_0100; in_sel = 2'd1;
    step();
    chk("p1_in_data_e1", {24'h0, in_data}, 32'h0);
    step();
    chk("p1_in_data_e2", {24'h0, in_data}, 32'h01);
    chk("p1_pending_e2", {28'h0, ev_pending}, 32'h0);
    step();
    chk("p1_pending_e3", {28'h0, ev_pending}, 32'h2);
    chk("p1_irq_e3", {31'h0, irq}, 32'h1);
    in_rd = 1'b1;
    step();
    chk("p1_clear", {28'h0, ev_pending}, 32'h0);
    chk("p1_irq_clear", {31'h0, irq}, 32'h0);
    in_rd = 1'b0;

    // Set/clear collision on port0
    in_ports = 32'h0000_0180;
    step(); step();
    in_rd = 1'b1; in_sel = 2'd0;
    step();
    chk("collision_set_wins", {28'h0, ev_pending}, 32'h1);
    step();
    chk("collision_then_clear", {28'h0, ev_pending}, 32'h0);
    in_rd = 1'b0;

    // Masked port2 change never raises a flag, even once unmasked
    ev_en = 4'b1011; in_ports = 32'h0055_0180;
    for (int i = 0; i < 4; i++) step();
    chk("mask_blocks", {28'h0, ev_pending}, 32'h0);
    ev_en = 4'hF;
    for (int i = 0; i < 3; i++) step();
    chk("unmask_no_late_event", {28'h0, ev_pending}, 32'h0);

    // Mid-operation reset overrides a concurrent write
    in_ports = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) step();
    chk("pre_reset_pending", {28'h0, ev_pending}, 32'hF);
    chk("pre_reset_out", out_ports, 32'hAB00_0011);
    reset = 1'b1; out_we = 1'b1; out_sel = 2'd1; out_data = 8'h77;
    step();
    chk("midreset_out", out_ports, 32'h0);
    chk("midreset_pending", {28'h0, ev_pending}, 32'h0);
    chk("midreset_irq", {31'h0, irq}, 32'h0);
    chk("midreset_in_data", {24'h0, in_data}, 32'h0);
    reset = 1'b0; out_we = 1'b0;
    step();
    chk("warm_r1", {28'h0, ev_pending}, 32'h0);
    // This change reaches the change detector on the first unsuppressed cycle.
    in_ports = 32'h00FF_FFFF;
    step();
    chk("warm_r2", {28'h0, ev_pending}, 32'h0);
    step();
    chk("warm_r3", {28'h0, ev_pending}, 32'h0);
    step();
    chk("warm_first_event", {28'h0, ev_pending}, 32'h8);

    // NPORTS=3 instance: select 3 is out of range
    out_we3 = 1'b1; out_sel3 = 2'd1; out_data3 = 8'h42;
    step();
    chk("p3_write", {8'h0, out_ports3}, 32'h004200);
    out_sel3 = 2'd3; out_data3 = 8'h99;
    step();
    chk("p3_write_oor_dropped", {8'h0, out_ports3}, 32'h004200);
    out_we3 = 1'b0; in_sel3 = 2'd2;
    #1 chk("p3_in_data", {24'h0, in_data3}, 32'h12);
    in_sel3 = 2'd3;
    #1 chk("p3_in_data_oor", {24'h0, in_data3}, 32'h0);

    // Randomized run against the reference model
    reset = 1'b1;
    step();
    model_reset();
    reset = 1'b0;
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 59) == 0);
      out_we   = 1'($urandom_range(0, 1));
      out_sel  = 2'($urandom);
      out_data = 8'($urandom);
      in_rd    = ($urandom_range(0, 3) == 0);
      in_sel   = 2'($urandom);
      if ($urandom_range(0, 7) == 0) ev_en = 4'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        int p;
        p = $urandom_range(0, 3);
        in_ports = in_ports ^ (32'($urandom_range(1, 255)) << (8 * p));
      end
      step();
      if (reset) model_reset();
      else model_edge();
      model_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
